tone_phase_sequencer: RTL and testbench
=======================================

Name: tone_phase_sequencer

Overview:
Time-multiplexed per-voice phase accumulator that sits directly downstream of the 256x24 tone-constant ROM. On every sample tick it scans all voices in turn. For each voice it presents the voice's key number as the ROM address, takes back the registered 24-bit phase increment one cycle later, and adds it into that voice's phase accumulator. The updated phases stream out to the oscillator/wavetable stage with voice index and a valid strobe.

Parameters:
VOICES, 8, number of voices scanned per sample tick (power of 2)
V_WIDTH, 3, voice index width, log2(VOICES)
ADDR_WIDTH, 8, ROM address / key number width
DATA_WIDTH, 24, ROM word (phase increment) width
PHASE_WIDTH, 32, phase accumulator width (>= DATA_WIDTH+1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
sample_tick  in  1  one-cycle pulse that starts a voice scan
note_we  in  1  note register write strobe
note_wr_voice  in  V_WIDTH  voice written by note_we
note_wr_key  in  ADDR_WIDTH  key number (ROM address) for that voice
note_wr_gate  in  1  gate for that voice (1 = sounding)
rom_addr  out  ADDR_WIDTH  registered address to tone ROM
rom_q  in  DATA_WIDTH  ROM data, valid one clk after rom_addr
phase_out  out  PHASE_WIDTH  updated phase of voice phase_voice
phase_voice  out  V_WIDTH  voice index of phase_out
phase_valid  out  1  one-cycle strobe qualifying phase_out/phase_voice
busy  out  1  scan in progress
overrun  out  1  one-cycle pulse: sample_tick arrived while busy

Behaviour:
- Reset (async, immediate): all key regs 0, gates 0, accumulators 0. rom_addr, phase_out, phase_voice 0. phase_valid, busy, overrun 0. Scan counter 0, pipeline flushed. Reset mid-scan aborts the scan; no further phase_valid until the next tick after reset releases.
- Pipeline, 3 stages, throughput 1 voice/clk. Tick sampled in cycle T:
  - stage A drives rom_addr = key[v] in cycle T+1+v
  - stage B sees rom_q for voice v in cycle T+2+v and computes acc[v] + increment
  - phase_out, phase_voice = v, phase_valid = 1 are registered outputs visible in cycle T+3+v
- busy high cycles T+1 .. T+VOICES+1; low in cycle T+VOICES+2, which is also the cycle of the last phase_valid.
- A tick in the cycle busy is low is accepted, so back-to-back scans are possible.
- Increment = rom_q zero-extended to PHASE_WIDTH if gate[v]=1, else 0. Gated-off voices still emit phase_valid with their held phase.
- Accumulator wraps modulo 2^PHASE_WIDTH. No saturation.
- sample_tick while busy: ignored, scan unaffected, overrun=1 for exactly the following cycle.
- Note write: key[note_wr_voice] and gate[...] update on the write edge.
  - A voice whose address was already issued in the current scan uses the old key.
  - Retrigger: a write with note_wr_gate=1 to a voice whose gate was 0 clears acc[voice] to 0.
  - If that clear hits in the same cycle as stage B accumulates the same voice, the clear wins: acc=0, and the emitted phase_out is 0.
- Gate 1->0 holds acc (no clear).
- rom_addr holds its last value when idle.

Optional Feature:
PITCH_BEND_EN: adds port pitch_bend in 8, signed, global.
- Stage B increment becomes rom_q + ((rom_q * pitch_bend) >>> 10). rom_q is treated as unsigned 24-bit; the product is 33-bit signed. The result is non-negative, and is zero-extended then added.
- Pipeline latency is unchanged.
- Without the macro there is no port and increment = rom_q exactly.

Test Plan:
- Basic accumulate: voice0 key 60, gate 1, bench ROM[60]=0x000100; three ticks spaced 20 clks -> voice0 phase_out 0x100, 0x200, 0x300; voices 1-7 phase_out 0 with phase_valid each scan.
- Timing: tick at cycle T -> rom_addr=key0 at T+1, key7 at T+8; phase_valid voice0 at T+3, voice7 at T+10; busy high T+1..T+9, low T+10; a tick at T+10 starts a new scan.
- Overrun: ticks at T and T+4 -> overrun high only at T+5; exactly 8 phase_valid strobes, voices 0..7 in order.
- Wrap: voice3 acc preloaded via scans to 0xFFFFFF00 with ROM increment 0x200 -> phase_out 0x00000100.
- Retrigger collision: voice2 gate 0, acc 0x500; write gate=1 in the cycle stage B processes voice2 -> phase_out 0, next scan 0 + increment.
- Reset mid-scan: assert reset at T+5 for 2 cycles -> all outputs 0 immediately, no phase_valid until next tick; with PITCH_BEND_EN, bend=+64, ROM=0x000400 -> increment 0x000400+0x40=0x440.

Source files
------------

// File: rtl/tone_phase_sequencer.sv
// Per-voice phase accumulator scanning all voices through the registered tone ROM on each sample tick.
// Optional build macro PITCH_BEND_EN adds a global signed pitch_bend input that scales each ROM increment.
module tone_phase_sequencer #(
    parameter int VOICES      = 8,
    parameter int V_WIDTH     = 3,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 24,
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   note_we,
    input  logic [V_WIDTH-1:0]     note_wr_voice,
    input  logic [ADDR_WIDTH-1:0]  note_wr_key,
    input  logic                   note_wr_gate,
`ifdef PITCH_BEND_EN
    input  logic signed [7:0]      pitch_bend,
`endif
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic [V_WIDTH-1:0]     phase_voice,
    output logic                   phase_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [V_WIDTH-1:0] LAST = V_WIDTH'(VOICES - 1);

`ifdef PITCH_BEND_EN
    // inc = q + (q * bend) >>> 10; bend range keeps the result non-negative
    function automatic logic [PHASE_WIDTH-1:0] calc_inc(input logic [DATA_WIDTH-1:0] q,
                                                        input logic signed [7:0] pb);
        logic signed [DATA_WIDTH+8:0] qs;
        logic signed [DATA_WIDTH+8:0] ps;
        logic signed [DATA_WIDTH+8:0] prod;
        logic signed [DATA_WIDTH+8:0] sh;
        logic signed [DATA_WIDTH+9:0] s;
        qs   = {9'b0, q};
        ps   = {{(DATA_WIDTH+1){pb[7]}}, pb};
        prod = qs * ps;
        sh   = prod >>> 10;
        s    = {10'b0, q} + {sh[DATA_WIDTH+8], sh};
        return PHASE_WIDTH'($unsigned(s));
    endfunction
`else
    function automatic logic [PHASE_WIDTH-1:0] calc_inc(input logic [DATA_WIDTH-1:0] q);
        return PHASE_WIDTH'(q);
    endfunction
`endif

    logic [ADDR_WIDTH-1:0]  key_q  [VOICES];
    logic                   gate_q [VOICES];
    logic [PHASE_WIDTH-1:0] acc_q  [VOICES];

    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   vld_p0_q, vld_p0_d;
    logic [V_WIDTH-1:0]     voice_p0_q, voice_p0_d;
    logic [ADDR_WIDTH-1:0]  addr_p0_q, addr_p0_d;
    logic                   vld_p1_q;
    logic [V_WIDTH-1:0]     voice_p1_q;
    logic                   vld_p2_q;
    logic [V_WIDTH-1:0]     voice_p2_q;
    logic [PHASE_WIDTH-1:0] phase_p2_q, phase_p2_d;

    logic                   start;
    logic                   retrig;
    logic                   clear_hit;
    logic [PHASE_WIDTH-1:0] inc_p1;
    logic [PHASE_WIDTH-1:0] sum_p1;

    always_comb begin
        start      = sample_tick & ~busy_q;
        overrun_d  = sample_tick & busy_q;
        // stage p0: issue one ROM address per clock
        vld_p0_d   = start | (vld_p0_q & (voice_p0_q != LAST));
        voice_p0_d = voice_p0_q;
        if (start)
            voice_p0_d = '0;
        else if (vld_p0_q)
            voice_p0_d = voice_p0_q + V_WIDTH'(1);
        addr_p0_d  = vld_p0_d ? key_q[voice_p0_d] : addr_p0_q;
        busy_d     = busy_q;
        if (start)
            busy_d = 1'b1;
        else if (vld_p1_q && (voice_p1_q == LAST))
            busy_d = 1'b0;
        // stage p1: ROM word is back, accumulate
`ifdef PITCH_BEND_EN
        inc_p1     = gate_q[voice_p1_q] ? calc_inc(rom_q, pitch_bend) : '0;
`else
        inc_p1     = gate_q[voice_p1_q] ? calc_inc(rom_q) : '0;
`endif
        sum_p1     = acc_q[voice_p1_q] + inc_p1;
        retrig     = note_we & note_wr_gate & ~gate_q[note_wr_voice];
        clear_hit  = retrig & vld_p1_q & (note_wr_voice == voice_p1_q);
        phase_p2_d = phase_p2_q;
        if (vld_p1_q)
            phase_p2_d = clear_hit ? '0 : sum_p1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                key_q[i]  <= '0;
                gate_q[i] <= 1'b0;
                acc_q[i]  <= '0;
            end
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            vld_p0_q   <= 1'b0;
            voice_p0_q <= '0;
            addr_p0_q  <= '0;
            vld_p1_q   <= 1'b0;
            voice_p1_q <= '0;
            vld_p2_q   <= 1'b0;
            voice_p2_q <= '0;
            phase_p2_q <= '0;
        end else begin
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            vld_p0_q   <= vld_p0_d;
            voice_p0_q <= voice_p0_d;
            addr_p0_q  <= addr_p0_d;
            vld_p1_q   <= vld_p0_q;
            voice_p1_q <= voice_p0_q;
            // stage p2: registered outputs
            vld_p2_q   <= vld_p1_q;
            if (vld_p1_q)
                voice_p2_q <= voice_p1_q;
            phase_p2_q <= phase_p2_d;
            if (vld_p1_q)
                acc_q[voice_p1_q] <= sum_p1;
            // a retrigger clear is written last so it beats a same-voice accumulate
            if (note_we) begin
                key_q[note_wr_voice]  <= note_wr_key;
                gate_q[note_wr_voice] <= note_wr_gate;
                if (retrig)
                    acc_q[note_wr_voice] <= '0;
            end
        end
    end

    assign rom_addr    = addr_p0_q;
    assign phase_out   = phase_p2_q;
    assign phase_voice = voice_p2_q;
    assign phase_valid = vld_p2_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_tone_phase_sequencer.sv
// Directed bench for tone_phase_sequencer with a registered 256x24 ROM model.
module tb_tone_phase_sequencer;

    logic        clk;
    logic        reset;
    logic        sample_tick;
    logic        note_we;
    logic [2:0]  note_wr_voice;
    logic [7:0]  note_wr_key;
    logic        note_wr_gate;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q;
    logic [31:0] phase_out;
    logic [2:0]  phase_voice;
    logic        phase_valid;
    logic        busy;
    logic        overrun;
`ifdef PITCH_BEND_EN
    logic signed [7:0] pitch_bend;
`endif

    tone_phase_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .note_we      (note_we),
        .note_wr_voice(note_wr_voice),
        .note_wr_key  (note_wr_key),
        .note_wr_gate (note_wr_gate),
`ifdef PITCH_BEND_EN
        .pitch_bend   (pitch_bend),
`endif
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .phase_out    (phase_out),
        .phase_voice  (phase_voice),
        .phase_valid  (phase_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    logic [23:0] mem [256];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_q <= mem[rom_addr];

    typedef struct {
        int          cyc;
        int          voice;
        logic [31:0] ph;
    } ev_t;

    typedef struct {
        int          voice;
        logic [7:0]  key;
        logic        gate;
        logic [23:0] rom;
        logic [31:0] inc;
    } vec_t;

    ev_t  evq[$];
    int   ovrq[$];
    int   cyc;
    int   checks;
    int   failures;
    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (phase_valid) evq.push_back('{cyc, int'(phase_voice), phase_out});
        if (overrun) ovrq.push_back(cyc);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_voice(input string nm, input int t, input int v, input logic [31:0] exp);
        bit          found;
        logic [31:0] ph;
        found = 0;
        ph    = '0;
        foreach (evq[i])
            if (evq[i].voice == v && evq[i].cyc == t + 3 + v) begin
                found = 1;
                ph    = evq[i].ph;
            end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_strobe expected=%h at cycle T+%0d", nm, exp, 3 + v);
        end else begin
            chk(nm, ph, exp);
        end
    endtask

    task automatic note_write(input int v, input logic [7:0] key, input logic gate);
        note_we       = 1'b1;
        note_wr_voice = 3'(v);
        note_wr_key   = key;
        note_wr_gate  = gate;
        step();
        note_we       = 1'b0;
    endtask

    task automatic run_scan(output int t);
        evq.delete();
        sample_tick = 1'b1;
        t = cyc;
        step();
        sample_tick = 1'b0;
        repeat (9) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int T;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        reset         = 1'b1;
        sample_tick   = 1'b0;
        note_we       = 1'b0;
        note_wr_voice = '0;
        note_wr_key   = '0;
        note_wr_gate  = 1'b0;
`ifdef PITCH_BEND_EN
        pitch_bend    = '0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = '0;

        tbl[0] = '{0, 8'd60,  1'b1, 24'h000100, 32'h0000_0100};
        tbl[1] = '{1, 8'd61,  1'b0, 24'h000777, 32'h0000_0000};
        tbl[2] = '{2, 8'd62,  1'b0, 24'h000000, 32'h0000_0000};
        tbl[3] = '{3, 8'd10,  1'b1, 24'h123456, 32'h0012_3456};
        tbl[4] = '{4, 8'd255, 1'b1, 24'hFFFFFF, 32'h00FF_FFFF};
        tbl[5] = '{5, 8'd0,   1'b1, 24'h000001, 32'h0000_0001};
        tbl[6] = '{6, 8'd62,  1'b1, 24'h000000, 32'h0000_0000};
        tbl[7] = '{7, 8'd100, 1'b0, 24'hABCDEF, 32'h0000_0000};

        // reset state
        step();
        step();
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_phase_out", phase_out, 32'h0);
        chk("rst_phase_voice", 32'(phase_voice), 32'h0);
        chk("rst_phase_valid", 32'(phase_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        step();

        // table-driven accumulate over three scans spaced 20 clocks
        for (int i = 0; i < 8; i++) begin
            mem[tbl[i].key] = tbl[i].rom;
            note_write(tbl[i].voice, tbl[i].key, tbl[i].gate);
        end
        for (int k = 1; k <= 3; k++) begin
            run_scan(T);
            chk($sformatf("basic_count_k%0d", k), 32'(evq.size()), 32'd8);
            for (int i = 0; i < 8; i++)
                chk_voice($sformatf("basic_k%0d_v%0d", k, tbl[i].voice), T, tbl[i].voice,
                          tbl[i].inc * 32'(k));
            repeat (10) step();
        end

        // timing of one scan and a back-to-back tick in the busy-low cycle
        evq.delete();
        ovrq.delete();
        sample_tick = 1'b1;
        T = cyc;
        for (int k = 1; k <= 10; k++) begin
            step();
            sample_tick = 1'b0;
            if (k == 1) begin
                chk("tim_addr_key0", 32'(rom_addr), 32'd60);
                chk("tim_busy_t1", 32'(busy), 32'd1);
            end
            if (k == 2) chk("tim_valid_t2", 32'(phase_valid), 32'd0);
            if (k == 3) begin
                chk("tim_valid_t3", 32'(phase_valid), 32'd1);
                chk("tim_voice_t3", 32'(phase_voice), 32'd0);
            end
            if (k == 8) chk("tim_addr_key7", 32'(rom_addr), 32'd100);
            if (k == 9) chk("tim_busy_t9", 32'(busy), 32'd1);
            if (k == 10) begin
                chk("tim_busy_t10", 32'(busy), 32'd0);
                chk("tim_valid_t10", 32'(phase_valid), 32'd1);
                chk("tim_voice_t10", 32'(phase_voice), 32'd7);
                sample_tick = 1'b1;
            end
        end
        chk_voice("tim_v0", T, 0, 32'h400);
        chk_voice("tim_v7", T, 7, 32'h0);
        step();
        sample_tick = 1'b0;
        chk("tim_b2b_busy", 32'(busy), 32'd1);
        chk("tim_b2b_addr", 32'(rom_addr), 32'd60);
        repeat (12) step();
        chk("tim_no_overrun", 32'(ovrq.size()), 32'd0);

        // tick while busy: overrun pulse, scan undisturbed
        evq.delete();
        ovrq.delete();
        sample_tick = 1'b1;
        T = cyc;
        for (int k = 1; k <= 15; k++) begin
            step();
            sample_tick = (k == 4);
        end
        chk("ovr_pulses", 32'(ovrq.size()), 32'd1);
        if (ovrq.size() > 0) chk("ovr_cycle", 32'(ovrq[0] - T), 32'd5);
        chk("ovr_strobes", 32'(evq.size()), 32'd8);
        for (int i = 0; i < evq.size() && i < 8; i++) begin
            chk($sformatf("ovr_order_%0d", i), 32'(evq[i].voice), 32'(i));
            chk($sformatf("ovr_cyc_%0d", i), 32'(evq[i].cyc - T), 32'(3 + i));
        end

        // accumulator wrap
        do_reset();
        mem[200] = 24'hFFFFFF;
        mem[201] = 24'h000200;
        note_write(3, 8'd200, 1'b1);
        for (int s = 0; s < 256; s++) run_scan(T);
        chk_voice("wrap_pre", T, 3, 32'hFFFF_FF00);
        note_write(3, 8'd201, 1'b1);
        run_scan(T);
        chk_voice("wrap", T, 3, 32'h0000_0100);

        // gate-off hold, then retrigger colliding with stage B of the same voice
        do_reset();
        mem[20] = 24'h000500;
        note_write(2, 8'd20, 1'b1);
        run_scan(T);
        chk_voice("retrig_load", T, 2, 32'h500);
        note_write(2, 8'd20, 1'b0);
        run_scan(T);
        chk_voice("gateoff_hold", T, 2, 32'h500);
        evq.delete();
        sample_tick = 1'b1;
        T = cyc;
        for (int k = 1; k <= 10; k++) begin
            step();
            sample_tick = 1'b0;
            note_we     = 1'b0;
            if (k == 4) begin
                note_we       = 1'b1;
                note_wr_voice = 3'd2;
                note_wr_key   = 8'd20;
                note_wr_gate  = 1'b1;
            end
        end
        chk_voice("retrig_clear", T, 2, 32'h0);
        run_scan(T);
        chk_voice("retrig_next", T, 2, 32'h500);

        // reset in the middle of a scan
        do_reset();
        for (int v = 0; v < 8; v++) note_write(v, 8'd60, 1'b1);
        run_scan(T);
        chk_voice("rstmid_first", T, 2, 32'h100);
        evq.delete();
        sample_tick = 1'b1;
        T = cyc;
        for (int k = 1; k <= 5; k++) begin
            step();
            sample_tick = 1'b0;
        end
        chk("rstmid_pre_valid", 32'(phase_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_valid", 32'(phase_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_addr", 32'(rom_addr), 32'd0);
        chk("rstmid_phase", phase_out, 32'h0);
        chk("rstmid_voice", 32'(phase_voice), 32'd0);
        chk("rstmid_overrun", 32'(overrun), 32'd0);
        step();
        step();
        reset = 1'b0;
        evq.delete();
        repeat (15) step();
        chk("rstmid_no_strobe", 32'(evq.size()), 32'd0);
        chk("rstmid_idle_busy", 32'(busy), 32'd0);
        note_write(0, 8'd60, 1'b1);
        run_scan(T);
        chk_voice("rstmid_restart_v0", T, 0, 32'h100);
        chk_voice("rstmid_restart_v1", T, 1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
